// File: rtl/fetch_queue.sv
// RV32I prefetch queue between a request/response instruction memory and decode.
// Optional perf counters (perf_fetched, perf_squashed) are built when FETCH_PERF_EN is defined.
module fetch_queue #(
  parameter logic [31:0] ENTRYPOINT      = 32'h140,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_ex_base,
  input  logic [31:0] pc_ex_off,
  input  logic        pc_ex_valid,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [29:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        de_valid,
  input  logic        de_ready,
  output logic [31:0] insn,
  output logic [31:0] pc_de
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] inflight_q, inflight_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [31:0]   insn_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [31:0]   target;
  logic [OW-1:0] live;
  logic          req_fire;
  logic          rsp_ok;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  assign target = (pc_ex_base + pc_ex_off) & ~32'd3;
  assign live   = inflight_q - drop_q;

  // Credit check: queued plus live outstanding never exceeds the queue, so a push always fits.
  assign mem_req_valid = rst_n && !pc_ex_valid
                      && ((SW'(count_q) + SW'(live)) < SW'(DEPTH))
                      && (inflight_q < OW'(MAX_OUTSTANDING));
  assign mem_addr      = pc_q[31:2];

  assign de_valid = rst_n && (count_q != '0);
  assign insn     = de_valid ? insn_mem_q[head_q] : 32'd0;
  assign pc_de    = de_valid ? pc_mem_q[head_q]   : 32'd0;

  assign req_fire = mem_req_valid && mem_req_ready;
  assign rsp_ok   = mem_rsp_valid && (inflight_q != '0);
  assign rsp_drop = rsp_ok && (pc_ex_valid || (drop_q != '0));
  assign push     = rsp_ok && !rsp_drop;
  assign pop      = de_valid && de_ready && !pc_ex_valid;

  // Next-state: handshake, response and pop net out; a redirect overrides queue state.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + OW'(req_fire) - OW'(rsp_ok);

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      tail_d   = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (rsp_drop && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end

    if (pc_ex_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      drop_d   = inflight_q - OW'(rsp_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= ENTRYPOINT;
      rsp_pc_q   <= ENTRYPOINT;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Payload storage needs no reset; outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem_q[tail_q] <= mem_rsp_data;
      pc_mem_q[tail_q]   <= rsp_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_squashed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q  <= 32'd0;
      perf_squashed_q <= 32'd0;
    end else begin
      perf_fetched_q  <= perf_fetched_q + 32'(pop);
      perf_squashed_q <= perf_squashed_q + (pc_ex_valid ? 32'(count_q) : 32'd0) + 32'(rsp_drop);
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based model of the fetch stream.
module tb_fetch_queue;

  localparam logic [31:0] ENTRY = 32'h140;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_ex_base;
  logic [31:0] pc_ex_off;
  logic        pc_ex_valid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] insn;
  logic [31:0] pc_de;

  fetch_queue #(
    .ENTRYPOINT      (ENTRY),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_ex_base    (pc_ex_base),
    .pc_ex_off     (pc_ex_off),
    .pc_ex_valid   (pc_ex_valid),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .de_valid      (de_valid),
    .de_ready      (de_ready),
    .insn          (insn),
    .pc_de         (pc_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit stale; logic [31:0] pc; } os_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  typedef struct { logic [29:0] addr; int due; } mreq_t;

  os_t   oq[$];      // outstanding requests in issue order
  ent_t  mq[$];      // expected decode-visible queue
  mreq_t mem_q[$];   // bench memory pipeline
  logic [31:0] mpc;
  bit    fresh;
  int    cyc;
  int    last_due;
  int    n_total;
  int    n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int live_cnt();
    int n = 0;
    foreach (oq[i]) if (!oq[i].stale) n++;
    return n;
  endfunction

  // One cycle: drive at negedge, check after settling, advance model and memory, clock.
  task automatic step(input bit rn, input bit rd, input logic [31:0] base,
                      input logic [31:0] off, input bit dr, input bit mr, input int lat);
    bit  exp_req, exp_dv, req, pop, took_rsp;
    int  due;
    os_t o;
    rst_n         = rn;
    pc_ex_valid   = rd;
    pc_ex_base    = base;
    pc_ex_off     = off;
    de_ready      = dr;
    mem_req_ready = mr;
    took_rsp      = rn && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    mem_rsp_valid = took_rsp;
    mem_rsp_data  = took_rsp ? 32'(mem_q[0].addr) : $urandom;
    #1;
    exp_dv  = rn && (mq.size() != 0);
    exp_req = rn && !rd && ((mq.size() + live_cnt()) < DEPTH) && (oq.size() < MAXO);
    check_eq("de_valid", 32'(de_valid), 32'(exp_dv));
    check_eq("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
    check_eq("mem_addr", 32'(mem_addr), 32'(mpc[31:2]));
    if (exp_dv) begin
      check_eq("pc_de", pc_de, mq[0].pc);
      check_eq("insn", insn, mq[0].insn);
    end else if (!rn || fresh) begin
      check_eq("pc_de_reset", pc_de, 32'd0);
      check_eq("insn_reset", insn, 32'd0);
    end

    if (!rn) begin
      mem_q.delete();
      last_due = -1;
    end else begin
      if (took_rsp) void'(mem_q.pop_front());
      if (mem_req_valid && mr) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        mem_q.push_back('{addr: mem_addr, due: due});
        last_due = due;
      end
    end

    if (!rn) begin
      mq.delete();
      oq.delete();
      mpc   = ENTRY;
      fresh = 1'b1;
    end else begin
      pop = exp_dv && dr && !rd;
      req = exp_req && mr;
      if (pop) void'(mq.pop_front());
      if (took_rsp && (oq.size() != 0)) begin
        o = oq.pop_front();
        if (!o.stale && !rd) mq.push_back('{pc: o.pc, insn: 32'(o.pc[31:2])});
      end
      if (rd) begin
        mq.delete();
        foreach (oq[i]) oq[i].stale = 1'b1;
        mpc = (base + off) & ~32'd3;
      end
      if (req) begin
        oq.push_back('{stale: 1'b0, pc: mpc});
        mpc = mpc + 32'd4;
      end
      if (mq.size() != 0) fresh = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit dr, input int lat);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 32'd0, dr, 1'b1, lat);
  endtask

  initial begin
    n_total = 0; n_bad = 0; cyc = 0; last_due = -1;
    mpc = ENTRY; fresh = 1'b1;
    rst_n = 1'b0; pc_ex_valid = 1'b0; pc_ex_base = 32'd0; pc_ex_off = 32'd0;
    de_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    @(negedge clk);

    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1);
    run(20, 1'b1, 1);                                  // zero-wait free run
    run(10, 1'b0, 1);                                  // decode stall fills queue
    run(12, 1'b1, 1);
    run(8, 1'b1, 3);                                   // 3-cycle memory, then redirect
    step(1'b1, 1'b1, 32'h200, 32'hFFFF_FFF0, 1'b1, 1'b1, 3);
    run(14, 1'b1, 3);
    run(6, 1'b1, 1);                                   // redirect to unaligned target
    step(1'b1, 1'b1, 32'h200, 32'h3, 1'b1, 1'b1, 1);
    run(8, 1'b1, 1);
    run(8, 1'b0, 1);                                   // full queue, then reset
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1);
    run(12, 1'b1, 1);
    step(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h8, 1'b1, 1'b1, 2);  // PC wrap
    run(10, 1'b1, 2);
    step(1'b1, 1'b1, 32'h1000, 32'h0, 1'b1, 1'b1, 2);        // back-to-back redirects
    step(1'b1, 1'b1, 32'h2000, 32'h4, 1'b1, 1'b1, 2);
    run(10, 1'b1, 2);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 400) != 0, ($urandom % 12) == 0, $urandom, $urandom,
           ($urandom % 4) != 0, ($urandom % 3) != 0, 1 + int'($urandom % 5));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation RV32I fetch stage. Replaces the single-register fetch with a parametrised prefetch queue over a request/response instruction-memory port that tolerates variable latency.
- Decouples the instruction-memory port from decode with a valid/ready handshake.
- Squashes wrong-path instructions on an execute-stage redirect, including responses still in flight.
- Sits between instruction memory and decode; decode back-pressure replaces the old stall input.

Parameters:
- ENTRYPOINT, 32'h140, reset PC; bits [1:0] must be 0.
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered memory requests, live plus stale; 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- pc_ex_base  in  32  redirect base from execute.
- pc_ex_off  in  32  redirect offset from execute.
- pc_ex_valid  in  1  redirect strobe; target = pc_ex_base + pc_ex_off.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  30  word address, pc[31:2].
- mem_rsp_valid  in  1  response valid; responses return in request order.
- mem_rsp_data  in  32  fetched instruction word.
- de_valid  out  1  insn/pc_de valid toward decode.
- de_ready  in  1  decode accepts.
- insn  out  32  instruction at the queue head.
- pc_de  out  32  PC of insn.

Behaviour:
- Reset (rst_n=0 at posedge): pc=ENTRYPOINT, rsp_pc=ENTRYPOINT, queue empty, inflight=0, drop=0.
  - Outputs during and after reset: de_valid=0, mem_req_valid=0, insn=0, pc_de=0.
  - Reset mid-operation discards all state. Memory must be reset on the same rst_n, so no pre-reset response arrives afterwards.
- Counters:
  - count: queue occupancy, 0..DEPTH.
  - inflight: outstanding requests, 0..MAX_OUTSTANDING.
  - drop: stale outstanding requests, drop ≤ inflight.
  - live = inflight - drop.
- Request issue: mem_req_valid = !pc_ex_valid && (count + live < DEPTH) && (inflight < MAX_OUTSTANDING).
  - mem_req_valid is combinational from registered state plus pc_ex_valid.
  - On handshake (mem_req_valid && mem_req_ready): pc <= pc+4 (wraps mod 2^32); inflight increments.
  - mem_addr is always pc[31:2], including when mem_req_valid=0.
- Response:
  - On mem_rsp_valid, inflight decrements.
  - If drop>0: discard the response; drop decrements.
  - Otherwise: push {rsp_pc, mem_rsp_data}; rsp_pc <= rsp_pc+4.
  - The credit rule guarantees a push never hits a full queue. A response with inflight=0 is a protocol error: assertion in simulation, ignored in RTL.
- Decode side:
  - de_valid = (count != 0); insn/pc_de come from the head entry, registered storage with no combinational path from mem_rsp.
  - Pop on de_valid && de_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Minimum latency, request accept to de_valid: memory latency + 1 cycle.
  - insn/pc_de hold their values while de_valid && !de_ready.
- Redirect (pc_ex_valid=1 at posedge):
  - Target = (pc_ex_base + pc_ex_off) with bits [1:0] forced to 0; 32-bit wrap.
  - pc <= target; rsp_pc <= target.
  - Queue flushed: count=0 and de_valid=0 next cycle. A pop in the same cycle is ignored.
  - No request is issued that cycle.
  - drop <= inflight - mem_rsp_valid: every remaining outstanding request becomes stale. A response arriving in the redirect cycle is discarded and decrements inflight.
  - Back-to-back redirects: the last one wins; drop recomputes each cycle.
- Simultaneous events in a non-redirect cycle: request handshake, response, and pop are all applied in the same cycle; the counters net out.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32) and perf_squashed (32), both reset to 0, wrapping.
  - perf_fetched increments on each decode pop.
  - perf_squashed increments by (count at redirect) on each redirect, plus 1 per discarded stale response.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then free run, zero-wait memory returning word = address, de_ready=1 → first de_valid at pc_de=0x140, insn=0x50; then 0x144, 0x148, ... on consecutive cycles.
- de_ready=0 for 10 cycles, DEPTH=4 → count reaches 4 and mem_req_valid=0. Head holds pc_de=0x140. On release, 0x140..0x14C drain in order with no gaps or duplicates.
- 3-cycle memory latency, redirect base=0x200, off=-0x10, with 3 requests in flight → drop=3, the three stale responses are discarded, next de_valid shows pc_de=0x1F0.
- Redirect with target 0x203 in the same cycle as mem_rsp_valid and a decode pop → the response is discarded, no pop takes effect, mem_addr=0x80 (pc=0x200) next cycle.
- rst_n low for 1 cycle mid-stream with the queue full → the next cycle has de_valid=0, count=0 and mem_addr=0x50, and fetching restarts at 0x140.
- With FETCH_PERF_EN defined: 5 pops, then a redirect with 2 queued entries and 1 stale response → perf_fetched=5, perf_squashed=3.
